// File: rtl/gfx_fetch_sequencer.sv
// gfx_fetch_sequencer: character/bitmap fetch sequencing for the pixel sequencer.
// Owns VC/VCBASE/RC/VMLI, badline detection, display/idle state, the video-matrix
// line buffer, c-/g-access address generation and BA, all in the clk_dot4x domain.
// Optional feature: define GFX_IDLE_FETCH_EN to keep issuing g-accesses (to 3FFF)
// while idle; otherwise idle cycles issue no g-access and feed zeros downstream.
module gfx_fetch_sequencer #(
    parameter int LINE_LEN       = 40,
    parameter int FIRST_DMA_LINE = 48,
    parameter int LAST_DMA_LINE  = 247
) (
    input  logic        clk_dot4x,
    input  logic        rst,
    input  logic        clk_phi,
    input  logic        phi_phase_start_14,
    input  logic        phi_phase_start_15,
    input  logic [6:0]  cycle_num,
    input  logic [8:0]  raster_line,
    input  logic        den,
    input  logic [2:0]  yscroll,
    input  logic        ecm,
    input  logic        bmm,
    input  logic [3:0]  vm,
    input  logic [2:0]  cb,
    input  logic [11:0] cdata,
    input  logic [7:0]  gdata,
    output logic [13:0] c_addr,
    output logic        c_req,
    output logic [13:0] g_addr,
    output logic        g_req,
    output logic        ba,
    output logic        badline,
    output logic        idle,
    output logic [7:0]  pixels_read,
    output logic [11:0] char_read,
    output logic [2:0]  rc
);

    localparam int IDX_W = $clog2(LINE_LEN);
    localparam logic [IDX_W-1:0] VMLI_MAX = IDX_W'(LINE_LEN - 1);

    logic             den_seen_q, den_seen_d;
    logic             idle_q, idle_d;
    logic [9:0]       vc_q, vc_d;
    logic [9:0]       vcbase_q, vcbase_d;
    logic [IDX_W-1:0] vmli_q, vmli_d;
    logic [2:0]       rc_q, rc_d;
    logic [7:0]       pixels_read_q, pixels_read_d;
    logic [11:0]      char_read_q, char_read_d;
    logic [11:0]      linebuf_q [LINE_LEN];

    logic             ev_g, ev_c, g_capture;
    logic             in_c_win, in_g_win, in_ba_win;
    logic             badline_w, idle_w, buf_we;
    logic [11:0]      buf_entry;

    // Decode phase events, access windows, badline and effective idle state.
    always_comb begin
        ev_g      = !clk_phi && phi_phase_start_15;
        ev_c      = clk_phi && phi_phase_start_15;
        g_capture = !clk_phi && phi_phase_start_14;
        in_c_win  = (cycle_num >= 7'd15) && (cycle_num <= 7'd54);
        in_g_win  = (cycle_num >= 7'd16) && (cycle_num <= 7'd55);
        in_ba_win = (cycle_num >= 7'd12) && (cycle_num <= 7'd54);
        badline_w = den_seen_q
                    && (raster_line >= 9'(FIRST_DMA_LINE))
                    && (raster_line <= 9'(LAST_DMA_LINE))
                    && (raster_line[2:0] == yscroll);
        idle_w    = idle_q && !badline_w;
        buf_entry = linebuf_q[vmli_q];
    end

    assign c_addr      = {vm, vc_q};
    assign c_req       = !rst && clk_phi && in_c_win && badline_w;
`ifdef GFX_IDLE_FETCH_EN
    assign g_req       = !rst && !clk_phi && in_g_win;
`else
    assign g_req       = !rst && !clk_phi && in_g_win && !idle_w;
`endif
    assign ba          = !(badline_w && in_ba_win);
    assign badline     = badline_w;
    assign idle        = idle_w;
    assign rc          = rc_q;
    assign pixels_read = pixels_read_q;
    assign char_read   = char_read_q;
    assign buf_we      = c_req && phi_phase_start_15;

    // Build the g-access address for bitmap or character mode; ECM masks bits 10:9.
    always_comb begin
        if (bmm) begin
            g_addr = {cb[2], vc_q, rc_q};
        end else begin
            g_addr = {cb, buf_entry[7:0], rc_q};
        end
`ifdef GFX_IDLE_FETCH_EN
        if (idle_w) begin
            g_addr = 14'h3FFF;
        end
`endif
        if (ecm) begin
            g_addr[10:9] = 2'b00;
        end
    end

    // Next-state for the counters, display/idle state and pixel-sequencer outputs.
    always_comb begin
        den_seen_d    = den_seen_q;
        idle_d        = idle_q;
        vc_d          = vc_q;
        vcbase_d      = vcbase_q;
        vmli_d        = vmli_q;
        rc_d          = rc_q;
        pixels_read_d = pixels_read_q;
        char_read_d   = char_read_q;

        if (raster_line == 9'd0) begin
            den_seen_d = 1'b0;
        end else if ((raster_line == 9'(FIRST_DMA_LINE)) && den) begin
            den_seen_d = 1'b1;
        end

        if (badline_w) begin
            idle_d = 1'b0;
        end

        if (ev_g && (cycle_num == 7'd0) && (raster_line == 9'd0)) begin
            vcbase_d = 10'd0;
        end

        if (ev_g && (cycle_num == 7'd14)) begin
            vc_d   = vcbase_q;
            vmli_d = '0;
            if (badline_w) begin
                rc_d = 3'd0;
            end
        end

        if (ev_g && in_g_win && !idle_w) begin
            vc_d = vc_q + 10'd1;
            if (vmli_q != VMLI_MAX) begin
                vmli_d = vmli_q + 1'b1;
            end
        end

        if (g_capture && in_g_win) begin
            if (!idle_w) begin
                pixels_read_d = gdata;
                char_read_d   = buf_entry;
            end else begin
`ifdef GFX_IDLE_FETCH_EN
                pixels_read_d = gdata;
`else
                pixels_read_d = 8'd0;
`endif
                char_read_d   = 12'd0;
            end
        end

        if (ev_c && (cycle_num == 7'd58)) begin
            if ((rc_q == 3'd7) && !badline_w) begin
                idle_d   = 1'b1;
                vcbase_d = vc_q;
            end else if (!idle_w) begin
                rc_d = rc_q + 3'd1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            den_seen_q    <= 1'b0;
            idle_q        <= 1'b1;
            vc_q          <= 10'd0;
            vcbase_q      <= 10'd0;
            vmli_q        <= '0;
            rc_q          <= 3'd0;
            pixels_read_q <= 8'd0;
            char_read_q   <= 12'd0;
        end else begin
            den_seen_q    <= den_seen_d;
            idle_q        <= idle_d;
            vc_q          <= vc_d;
            vcbase_q      <= vcbase_d;
            vmli_q        <= vmli_d;
            rc_q          <= rc_d;
            pixels_read_q <= pixels_read_d;
            char_read_q   <= char_read_d;
        end
    end

    // Video-matrix line buffer: store c-data at the end of each badline c-access.
    always_ff @(posedge clk_dot4x) begin
        if (buf_we) begin
            linebuf_q[vmli_q] <= cdata;
        end
    end

endmodule

// File: tb/tb_gfx_fetch_sequencer.sv
// tb_gfx_fetch_sequencer: directed bench for gfx_fetch_sequencer. Phases are four
// ticks long here (tick 2 = phase_start_14, tick 3 = phase_start_15); expected
// g-access results are queued when gdata is driven and popped at PHI1 tick 3.
module tb_gfx_fetch_sequencer;

    logic        clk_dot4x = 1'b0;
    logic        rst;
    logic        clk_phi;
    logic        phi_phase_start_14;
    logic        phi_phase_start_15;
    logic [6:0]  cycle_num;
    logic [8:0]  raster_line;
    logic        den;
    logic [2:0]  yscroll;
    logic        ecm;
    logic        bmm;
    logic [3:0]  vm;
    logic [2:0]  cb;
    logic [11:0] cdata;
    logic [7:0]  gdata;
    logic [13:0] c_addr;
    logic        c_req;
    logic [13:0] g_addr;
    logic        g_req;
    logic        ba;
    logic        badline;
    logic        idle;
    logic [7:0]  pixels_read;
    logic [11:0] char_read;
    logic [2:0]  rc;

    typedef struct {
        logic [11:0] chr;
        logic [7:0]  pix;
        logic [13:0] gaddr;
        logic        gaddr_chk;
        logic        greq;
    } g_exp_t;

    g_exp_t      sb[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cur_line     = 0;
    int          cur_cyc      = 0;
    int          cur_phi      = 0;
    int          cur_tick     = 0;
    int          ysc_at       = 99;
    logic [2:0]  ysc_new      = 3'd0;
    int          g_bl_from    = 99;
    int          g_disp_from  = 99;
    logic [2:0]  g_rc_exp     = 3'd0;
    logic        g_fixed      = 1'b0;

    gfx_fetch_sequencer dut (
        .clk_dot4x          (clk_dot4x),
        .rst                (rst),
        .clk_phi            (clk_phi),
        .phi_phase_start_14 (phi_phase_start_14),
        .phi_phase_start_15 (phi_phase_start_15),
        .cycle_num          (cycle_num),
        .raster_line        (raster_line),
        .den                (den),
        .yscroll            (yscroll),
        .ecm                (ecm),
        .bmm                (bmm),
        .vm                 (vm),
        .cb                 (cb),
        .cdata              (cdata),
        .gdata              (gdata),
        .c_addr             (c_addr),
        .c_req              (c_req),
        .g_addr             (g_addr),
        .g_req              (g_req),
        .ba                 (ba),
        .badline            (badline),
        .idle               (idle),
        .pixels_read        (pixels_read),
        .char_read          (char_read),
        .rc                 (rc)
    );

    // Free-running dot clock.
    always #5 clk_dot4x = ~clk_dot4x;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic driveInputs();
        clk_phi            = cur_phi[0];
        phi_phase_start_14 = (cur_tick == 2);
        phi_phase_start_15 = (cur_tick == 3);
        cycle_num          = 7'(cur_cyc);
        raster_line        = 9'(cur_line);
        if (cur_phi == 1 && cur_cyc >= 15 && cur_cyc <= 54 && cur_cyc >= g_bl_from)
            cdata = 12'hA00 + 12'(cur_cyc - 15);
        else
            cdata = 12'h0EE;
        gdata = g_fixed ? 8'h55 : 8'(cur_cyc - 16 + cur_line);
    endtask

    task automatic applyStimulus();
        g_exp_t     e;
        int         k;
        logic [7:0] gd;
        @(posedge clk_dot4x);
        #1;
        cur_tick++;
        if (cur_tick == 4) begin
            cur_tick = 0;
            if (cur_phi == 0) begin
                cur_phi = 1;
            end else begin
                cur_phi = 0;
                cur_cyc++;
                if (cur_cyc == 63) begin
                    cur_cyc = 0;
                    cur_line++;
                end
            end
        end
        if (cur_cyc == ysc_at && cur_phi == 1 && cur_tick == 0) begin
            yscroll = ysc_new;
            ysc_at  = 99;
        end
        driveInputs();
        if (cur_phi == 0 && cur_tick == 0 && cur_cyc >= 16 && cur_cyc <= 55) begin
            k  = cur_cyc - 16;
            gd = g_fixed ? 8'h55 : 8'(cur_cyc - 16 + cur_line);
            if (cur_cyc >= g_disp_from) begin
                e.chr   = 12'hA00 + 12'(k);
                e.pix   = gd;
                e.gaddr = {cb, 8'(k), g_rc_exp};
                if (ecm) e.gaddr[10:9] = 2'b00;
                e.gaddr_chk = 1'b1;
                e.greq      = 1'b1;
            end else begin
                e.chr = 12'd0;
`ifdef GFX_IDLE_FETCH_EN
                e.pix       = gd;
                e.gaddr     = ecm ? 14'h39FF : 14'h3FFF;
                e.gaddr_chk = 1'b1;
                e.greq      = 1'b1;
`else
                e.pix       = 8'd0;
                e.gaddr     = 14'd0;
                e.gaddr_chk = 1'b0;
                e.greq      = 1'b0;
`endif
            end
            sb.push_back(e);
        end
    endtask

    task automatic doReset(input int line);
        rst      = 1'b1;
        cur_line = line;
        cur_cyc  = 0;
        cur_phi  = 0;
        cur_tick = 0;
        sb.delete();
        driveInputs();
        repeat (7) applyStimulus();
        #1;
        checkOutput("rst rc", 32'(rc), 0);
        checkOutput("rst idle", 32'(idle), 1);
        checkOutput("rst ba", 32'(ba), 1);
        checkOutput("rst badline", 32'(badline), 0);
        checkOutput("rst c_req", 32'(c_req), 0);
        checkOutput("rst g_req", 32'(g_req), 0);
        checkOutput("rst pixels_read", 32'(pixels_read), 0);
        checkOutput("rst char_read", 32'(char_read), 0);
        applyStimulus();
        rst = 1'b0;
    endtask

    task automatic runLine(input int bl_from, input int disp_from, input logic [2:0] rc_exp,
                           input int vc_start, input logic idle_end);
        int     c_first;
        logic   bl;
        logic   creq_exp;
        logic   done;
        g_exp_t e;
        g_bl_from   = bl_from;
        g_disp_from = disp_from;
        g_rc_exp    = rc_exp;
        c_first     = (bl_from > 15) ? bl_from : 15;
        done        = 1'b0;
        while (!done) begin
            #1;
            bl = (cur_cyc >= bl_from);
            if (cur_phi == 1 && cur_tick == 3) begin
                creq_exp = bl && cur_cyc >= 15 && cur_cyc <= 54;
                checkOutput($sformatf("badline L%0d C%0d", cur_line, cur_cyc), 32'(badline), 32'(bl));
                checkOutput($sformatf("ba L%0d C%0d", cur_line, cur_cyc), 32'(ba),
                            32'(!(bl && cur_cyc >= 12 && cur_cyc <= 54)));
                checkOutput($sformatf("c_req L%0d C%0d", cur_line, cur_cyc), 32'(c_req), 32'(creq_exp));
                if (creq_exp)
                    checkOutput($sformatf("c_addr L%0d C%0d", cur_line, cur_cyc), 32'(c_addr),
                                32'({vm, 10'(vc_start + cur_cyc - c_first)}));
                if (cur_cyc == 60)
                    checkOutput($sformatf("idle L%0d", cur_line), 32'(idle), 32'(idle_end));
            end
            if (cur_phi == 0 && cur_tick == 3 && cur_cyc >= 16 && cur_cyc <= 55) begin
                checkOutput($sformatf("sb_pending L%0d C%0d", cur_line, cur_cyc), 32'(sb.size()), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput($sformatf("g_req L%0d C%0d", cur_line, cur_cyc), 32'(g_req), 32'(e.greq));
                    checkOutput($sformatf("pixels_read L%0d C%0d", cur_line, cur_cyc), 32'(pixels_read), 32'(e.pix));
                    checkOutput($sformatf("char_read L%0d C%0d", cur_line, cur_cyc), 32'(char_read), 32'(e.chr));
                    if (e.gaddr_chk)
                        checkOutput($sformatf("g_addr L%0d C%0d", cur_line, cur_cyc), 32'(g_addr), 32'(e.gaddr));
                end
            end
            if (cur_phi == 0 && cur_tick == 3 && cur_cyc == 20)
                checkOutput($sformatf("rc L%0d", cur_line), 32'(rc), 32'(rc_exp));
            done = (cur_cyc == 62 && cur_phi == 1 && cur_tick == 3);
            applyStimulus();
        end
        checkOutput($sformatf("sb_drained L%0d", cur_line - 1), 32'(sb.size()), 0);
    endtask

    // Directed sequence: display frame, den-off frame, mid-line yscroll frame.
    initial begin
        vm      = 4'h5;
        cb      = 3'b010;
        ecm     = 1'b0;
        bmm     = 1'b0;
        den     = 1'b1;
        yscroll = 3'd0;
        g_fixed = 1'b0;

        doReset(48);
        runLine(1, 0, 3'd0, 0, 1'b0);
        for (int r = 1; r <= 7; r++)
            runLine(99, 0, 3'(r), 0, (r == 7));
        runLine(0, 0, 3'd0, 40, 1'b0);

        den     = 1'b0;
        ecm     = 1'b1;
        g_fixed = 1'b1;
        doReset(48);
        runLine(99, 99, 3'd0, 0, 1'b1);
        den     = 1'b1;
        yscroll = 3'd1;
        ecm     = 1'b0;
        g_fixed = 1'b0;
        runLine(99, 99, 3'd0, 0, 1'b1);

        yscroll = 3'd1;
        doReset(48);
        runLine(99, 99, 3'd0, 0, 1'b1);
        yscroll = 3'd0;
        ysc_at  = 30;
        ysc_new = 3'd1;
        runLine(30, 31, 3'd0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gfx_fetch_sequencer.md
Name: gfx_fetch_sequencer

Overview:
- Sequences the character/bitmap graphics fetches that feed the pixel sequencer's `pixels_read`/`char_read` inputs.
- Owns the VC/VCBASE/RC/VMLI counters, badline detection, display/idle state, the 40x12 video-matrix line buffer, c-access/g-access address generation and BA.
- Sits between the bus/memory interface and the pixel sequencer in the clk_dot4x domain.

Parameters:
- LINE_LEN, 40, number of c/g-access slots per raster line (line buffer depth).
- FIRST_DMA_LINE, 48, first raster line on which badlines may occur.
- LAST_DMA_LINE, 247, last raster line on which badlines may occur.

Ports:
- clk_dot4x  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- clk_phi  in  1  0 = PHI1 (g-access phase), 1 = PHI2 (c-access phase).
- phi_phase_start_14  in  1  one-tick strobe, second-to-last tick of each phase.
- phi_phase_start_15  in  1  one-tick strobe, last tick of each phase.
- cycle_num  in  7  raster cycle 0..62.
- raster_line  in  9  current raster line.
- den  in  1  display enable.
- yscroll  in  3  vertical scroll.
- ecm, bmm  in  1 each  display mode bits.
- vm  in  4  video matrix base (address bits 13:10).
- cb  in  3  char/bitmap base (address bits 13:11).
- cdata  in  12  c-access data {color[3:0], screen[7:0]}.
- gdata  in  8  g-access data.
- c_addr  out  14  c-access address.
- c_req  out  1  c-access active this PHI2.
- g_addr  out  14  g-access address.
- g_req  out  1  g-access active this PHI1.
- ba  out  1  bus available, active-low request.
- badline  out  1  badline condition.
- idle  out  1  1 = idle state.
- pixels_read  out  8  graphics byte to pixel sequencer.
- char_read  out  12  matching color/char word.
- rc  out  3  row counter.

Behaviour:
- Reset values: rc=0, vc=vcbase=0, vmli=0, idle=1, den_seen=0, ba=1, c_req=0, g_req=0, pixels_read=0, char_read=0, line buffer contents don't-care.
- den_seen: set on any tick with raster_line==FIRST_DMA_LINE && den; cleared at raster_line==0.
- badline (combinational): den_seen && FIRST_DMA_LINE<=raster_line<=LAST_DMA_LINE && raster_line[2:0]==yscroll. Re-evaluated every tick, so mid-line yscroll writes take effect immediately.
- While badline=1, idle is forced to 0 (display state).
- ba=0 when badline && 12<=cycle_num<=54, else 1.
- "Ev(p,c)" means the tick with clk_phi==p, phi_phase_start_15, cycle_num==c.
- Ev(0,0) with raster_line==0: vcbase<=0.
- Ev(0,14): vc<=vcbase; vmli<=0; if badline, rc<=0.
- c-access, cycles 15..54, PHI2:
  - c_req = badline; c_addr = {vm, vc}.
  - At Ev(1,c), if c_req: linebuf[vmli]<=cdata.
  - If a badline starts mid-line, only the remaining slots are refetched; the others keep stale data.
- g-access, cycles 16..55, PHI1:
  - g_req = !idle.
  - g_addr = bmm ? {cb[2], vc, rc} : {cb, linebuf[vmli][7:0], rc}.
  - If ecm, force g_addr[10:9]=0.
  - On tick clk_phi==0 && phi_phase_start_14: pixels_read<=gdata; char_read<=linebuf[vmli].
  - At Ev(0,c), while !idle: vc<=vc+1 (10-bit wrap) and vmli<=vmli+1, saturating at LINE_LEN-1.
  - Outputs are stable at the pixel sequencer's phi_phase_start_15 capture.
- Outside cycles 16..55, pixels_read/char_read hold.
- Ev(1,58):
  - If rc==7 && !badline: idle<=1, vcbase<=vc.
  - Else if !idle: rc<=rc+1 (3-bit wrap to 0).
  - If badline at rc==7, display continues and rc wraps to 0.
- rst asserted mid-line: all state returns to reset values on the next edge; no c-data is written to the buffer on that edge.

Optional Feature:
- Macro `GFX_IDLE_FETCH_EN`.
- Defined: in idle state, g-access still occurs in cycles 16..55:
  - g_req=1, g_addr=14'h3FFF (14'h39FF if ecm).
  - pixels_read<=gdata, char_read<=0.
  - vc and vmli do not advance.
- Undefined: in idle state, g_req=0, pixels_read<=0, char_read<=0.

Test Plan:
- Reset with den=1, raster_line=48, yscroll=0 -> during reset all outputs at reset values; after release, badline=1, ba=0 from cycle 12, c_req=1 in cycles 15..54.
- Badline line 48, cdata=12'hA00+slot, gdata=slot -> char_read=12'hA00+k with pixels_read=k for k=0..39, stable at each PHI1 phi_phase_start_15; c_addr runs vm:000..027.
- Eight display lines 48..55 -> rc steps 0..7; at line 55 cycle 58, idle=1 and vcbase=40; line 56 is a badline, so c_addr starts at vc=40.
- den=0 throughout line 48, den=1 afterwards -> badline never asserts that frame; idle stays 1.
- Write yscroll to match raster_line[2:0] at cycle 30 of a non-badline -> badline=1 at once, idle=0, c-accesses only in cycles 30..54, vmli continues from its current value.
- ecm=1, idle, `GFX_IDLE_FETCH_EN` defined, gdata=8'h55 -> g_addr=14'h39FF, pixels_read=8'h55, char_read=0. Without the macro: g_req=0, pixels_read=0.
